// File: rtl/post_box_fifo_engine.sv
// post_box_fifo_engine: Acorn POST pulse-protocol target engine with byte FIFOs to the host.
module post_box_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [7:0]                   din,
  input  logic                         pop,
  output logic [7:0]                   dout,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    r_mem [DEPTH];
  logic [LW-1:0] r_wp, r_rp;
  logic          w_push, w_pop;
  // a pop frees the slot the simultaneous push needs, so full+push+pop is lossless
  assign w_push = push && (!full || pop) && !flush;
  assign w_pop  = pop && !empty && !flush;
  assign level  = r_wp - r_rp;
  assign full   = level == LW'(DEPTH);
  assign empty  = level == '0;
  assign dout   = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + LW'(1);
      if (w_pop) r_rp <= r_rp + LW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= din;
  end
endmodule

module post_box_fifo_engine #(
  parameter int T2H_DEPTH    = 16,
  parameter int H2T_DEPTH    = 16,
  parameter int BREAK_CYCLES = 1200
) (
  input  logic                             fpga_clock_48mhz,
  input  logic                             reset_in,
  input  logic                             testreq_3v,
  output logic                             testack_noe,
  input  logic [7:0]                       h2t_data,
  input  logic                             h2t_valid,
  output logic                             h2t_ready,
  output logic [7:0]                       t2h_data,
  output logic                             t2h_valid,
  input  logic                             t2h_ready,
  output logic [$clog2(H2T_DEPTH+1)-1:0]   h2t_level,
  output logic [$clog2(T2H_DEPTH+1)-1:0]   t2h_level,
  input  logic                             flush,
  output logic [7:0]                       abort_count
);
  localparam int BW = $clog2(BREAK_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, OUT_BITS, IN_CHECK, IN_DATA} state_t;
  state_t        r_state;
  logic          r_req_s1, r_req_s2, r_req_d;
  logic [BW-1:0] r_low_cnt;
  logic [3:0]    r_pcnt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_sr, r_abort;
  logic          r_out_ok, r_noe;
  logic          w_pulse, w_break, w_chk, w_abort;
  logic [3:0]    w_pcnt_nxt;
  logic          w_h2t_push, w_h2t_pop, w_h2t_full, w_h2t_empty;
  logic          w_t2h_push, w_t2h_pop, w_t2h_full, w_t2h_empty;
  logic [7:0]    w_h2t_head;
  assign w_pulse    = r_req_s2 && !r_req_d;
  assign w_break    = !r_req_s2 && r_low_cnt == BW'(BREAK_CYCLES - 1);
  assign w_pcnt_nxt = (&r_pcnt) ? r_pcnt : r_pcnt + 4'd1;
  // input check happens on every IN_CHECK pulse and on the 4th pulse of a command group
  assign w_chk      = r_state == IN_CHECK || ((r_state == IDLE || r_state == OUT_BITS) && w_pcnt_nxt == 4'd4);
  assign w_h2t_pop  = w_pulse && w_chk && !w_h2t_empty && !flush;
  assign h2t_ready  = !w_h2t_full || w_h2t_pop;
  assign w_h2t_push = h2t_valid && h2t_ready;
  assign w_t2h_push = w_break && r_state == OUT_BITS && r_bitcnt == 3'd7 && (r_pcnt == 4'd1 || r_pcnt == 4'd2);
  assign w_t2h_pop  = t2h_valid && t2h_ready;
  assign t2h_valid  = !w_t2h_empty;
  assign w_abort    = !flush && ((w_pulse && r_state == OUT_BITS && w_pcnt_nxt == 4'd3) || (w_break && r_state == IN_DATA));
  assign testack_noe = r_noe;
  assign abort_count = r_abort;
  post_box_fifo #(.DEPTH(H2T_DEPTH)) u_h2t (
    .clk(fpga_clock_48mhz), .rst(reset_in), .flush(flush),
    .push(w_h2t_push), .din(h2t_data), .pop(w_h2t_pop), .dout(w_h2t_head),
    .level(h2t_level), .full(w_h2t_full), .empty(w_h2t_empty)
  );
  post_box_fifo #(.DEPTH(T2H_DEPTH)) u_t2h (
    .clk(fpga_clock_48mhz), .rst(reset_in), .flush(flush),
    .push(w_t2h_push), .din({r_sr[6:0], r_pcnt == 4'd1}), .pop(w_t2h_pop), .dout(t2h_data),
    .level(t2h_level), .full(w_t2h_full), .empty(w_t2h_empty)
  );
  always_ff @(posedge fpga_clock_48mhz or posedge reset_in) begin
    if (reset_in) begin
      r_req_s1  <= 1'b0;
      r_req_s2  <= 1'b0;
      r_req_d   <= 1'b0;
      r_low_cnt <= '0;
    end else begin
      r_req_s1  <= testreq_3v;
      r_req_s2  <= r_req_s1;
      r_req_d   <= r_req_s2;
      r_low_cnt <= r_req_s2 ? '0 : (r_low_cnt == BW'(BREAK_CYCLES)) ? r_low_cnt : r_low_cnt + BW'(1);
    end
  end
  always_ff @(posedge fpga_clock_48mhz or posedge reset_in) begin
    if (reset_in) begin
      r_state  <= IDLE;
      r_noe    <= 1'b1;
      r_pcnt   <= '0;
      r_bitcnt <= '0;
      r_sr     <= '0;
      r_out_ok <= 1'b0;
      r_abort  <= '0;
    end else begin
      if (flush) begin
        r_state  <= IDLE;
        r_noe    <= 1'b1;
        r_pcnt   <= '0;
        r_bitcnt <= '0;
        r_out_ok <= 1'b0;
      end else if (w_pulse) begin
        r_pcnt <= w_pcnt_nxt;
        if (w_chk) begin
          r_noe <= w_h2t_empty;
          if (!w_h2t_empty) begin
            r_sr     <= w_h2t_head;
            r_bitcnt <= '0;
            r_state  <= IN_DATA;
          end else begin
            r_state <= IN_CHECK;
          end
        end else if (r_state == IN_DATA) begin
          r_noe    <= !r_sr[7];
          r_sr     <= {r_sr[6:0], 1'b0};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) r_state <= IN_CHECK;
        end else if (w_pcnt_nxt == 4'd3) begin
          // an output command restarts from IDLE; the following break enters OUT_BITS
          r_noe    <= w_t2h_full;
          r_out_ok <= !w_t2h_full;
          r_state  <= IDLE;
        end else begin
          r_noe <= 1'b1;
        end
      end else if (w_break) begin
        r_noe    <= 1'b1;
        r_pcnt   <= '0;
        r_out_ok <= 1'b0;
        case (r_state)
          IDLE: begin
            if (r_pcnt == 4'd3 && r_out_ok) begin
              r_state  <= OUT_BITS;
              r_bitcnt <= '0;
            end
          end
          OUT_BITS: begin
            if (r_pcnt == 4'd1 || r_pcnt == 4'd2) begin
              r_sr     <= {r_sr[6:0], r_pcnt == 4'd1};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
      if (w_abort && r_abort != 8'hFF) r_abort <= r_abort + 8'd1;
    end
  end
endmodule

// File: tb/tb_post_box_fifo_engine.sv
// tb_post_box_fifo_engine: drives the POST pulse protocol and host streams, checks against queues.
module tb_post_box_fifo_engine;
  localparam int TD = 4;
  localparam int HD = 4;
  localparam int BC = 16;
  logic clk = 0, rst = 1, req = 0, noe, flush = 0;
  logic h2t_valid = 0, h2t_ready, t2h_valid, t2h_ready = 0;
  logic [7:0] h2t_data = 0, t2h_data, abort_count;
  logic [2:0] h2t_level, t2h_level;
  logic a;
  logic [7:0] e;
  typedef struct { logic [7:0] data; int level; } vec_t;
  vec_t vecs[3];
  logic [7:0] sb_t2h[$];
  logic [7:0] q_h2t[$];
  int n_chk = 0, n_fail = 0;

  post_box_fifo_engine #(.T2H_DEPTH(TD), .H2T_DEPTH(HD), .BREAK_CYCLES(BC)) dut (
    .fpga_clock_48mhz(clk), .reset_in(rst), .testreq_3v(req), .testack_noe(noe),
    .h2t_data(h2t_data), .h2t_valid(h2t_valid), .h2t_ready(h2t_ready),
    .t2h_data(t2h_data), .t2h_valid(t2h_valid), .t2h_ready(t2h_ready),
    .h2t_level(h2t_level), .t2h_level(t2h_level), .flush(flush), .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pulse(output logic ack);
    @(negedge clk) req = 1;
    repeat (4) @(negedge clk);
    ack = !noe;
    req = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic brk();
    repeat (BC + 4) @(negedge clk);
  endtask

  task automatic pulsebreak(input int n, output logic ack);
    for (int i = 0; i < n; i++) pulse(ack);
    brk();
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic k;
    for (int i = 7; i >= 0; i--) begin
      pulsebreak(b[i] ? 1 : 2, k);
      chk("out_bit_ack", k, 0);
    end
    sb_t2h.push_back(b);
  endtask

  task automatic drain();
    int x;
    for (int k = 0; k < TD + 2 && t2h_valid; k++) begin
      if (sb_t2h.size() != 0) x = sb_t2h.pop_front(); else x = 256;
      chk("t2h_data", t2h_data, x);
      t2h_ready = 1;
      @(negedge clk) t2h_ready = 0;
    end
    chk("t2h_drained_valid", t2h_valid, 0);
    chk("t2h_sb_leftover", sb_t2h.size(), 0);
  endtask

  task automatic host_push(input logic [7:0] b);
    h2t_data = b;
    h2t_valid = 1;
    @(negedge clk) h2t_valid = 0;
    q_h2t.push_back(b);
  endtask

  task automatic read_byte();
    logic k;
    logic [7:0] x;
    pulse(k);
    chk("in_check_ack", k, q_h2t.size() != 0);
    x = (q_h2t.size() != 0) ? q_h2t.pop_front() : 8'h00;
    for (int i = 7; i >= 0; i--) begin
      pulse(k);
      chk("in_bit_ack", k, x[i]);
    end
  endtask

  initial begin
    vecs[0] = '{8'h5A, 2};
    vecs[1] = '{8'h01, 3};
    vecs[2] = '{8'hFF, 4};
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_noe", noe, 1);
    chk("rst_h2t_ready", h2t_ready, 1);
    chk("rst_t2h_valid", t2h_valid, 0);
    chk("rst_h2t_level", h2t_level, 0);
    chk("rst_t2h_level", t2h_level, 0);
    chk("rst_abort", abort_count, 0);

    pulsebreak(4, a);
    chk("cmd4_empty_ack", a, 0);
    chk("cmd4_t2h_valid", t2h_valid, 0);
    chk("cmd4_h2t_level", h2t_level, 0);

    pulsebreak(3, a);
    chk("out_cmd_ack", a, 1);
    send_byte(8'hA8);
    chk("t2h_head_a8", t2h_data, 8'hA8);
    chk("t2h_level_a8", t2h_level, 1);
    for (int v = 0; v < 3; v++) begin
      pulsebreak(3, a);
      chk("vec_out_cmd_ack", a, 1);
      send_byte(vecs[v].data);
      chk("vec_t2h_level", t2h_level, vecs[v].level);
    end
    pulsebreak(3, a);
    chk("full_out_cmd_ack", a, 0);
    drain();

    pulsebreak(3, a);
    chk("glitch_cmd_ack", a, 1);
    pulsebreak(1, a);
    pulsebreak(1, a);
    pulsebreak(3, a);
    chk("glitch_recmd_ack", a, 1);
    chk("glitch_abort", abort_count, 1);
    send_byte(8'hAA);
    chk("glitch_t2h_head", t2h_data, 8'hAA);
    drain();

    host_push(8'h12);
    host_push(8'hFF);
    host_push(8'h34);
    chk("in_h2t_level", h2t_level, 3);
    for (int i = 1; i <= 3; i++) begin
      pulse(a);
      chk("in_grp_ack", a, i == 3);
    end
    read_byte();
    read_byte();
    read_byte();
    for (int i = 0; i < 23; i++) begin
      pulse(a);
      chk("empty_poll_ack", a, 0);
    end
    host_push(8'h2F);
    read_byte();
    brk();
    chk("in_abort_kept", abort_count, 1);
    chk("in_h2t_level_end", h2t_level, 0);

    for (int i = 1; i <= HD; i++) host_push(8'(i * 8'h11));
    chk("h2t_full_ready", h2t_ready, 0);
    chk("h2t_full_level", h2t_level, HD);
    for (int i = 1; i <= 3; i++) begin
      pulse(a);
      chk("full_grp_ack", a, i == 3);
    end
    h2t_data = 8'h55;
    h2t_valid = 1;
    pulse(a);
    h2t_valid = 0;
    chk("full_pop_ack", a, 1);
    chk("full_pushpop_level", h2t_level, HD);
    e = q_h2t.pop_front();
    q_h2t.push_back(8'h55);
    for (int i = 7; i >= 0; i--) begin
      pulse(a);
      chk("full_bit_ack", a, e[i]);
    end
    read_byte();
    pulse(a);
    chk("abort_check_ack", a, 1);
    e = q_h2t.pop_front();
    for (int i = 7; i >= 5; i--) begin
      pulse(a);
      chk("abort_bit_ack", a, e[i]);
    end
    brk();
    chk("in_data_abort", abort_count, 2);
    chk("in_data_abort_level", h2t_level, q_h2t.size());
    chk("in_data_abort_head", dut.w_h2t_head, q_h2t[0]);
    pulsebreak(3, a);
    chk("idle_after_abort_ack", a, 1);
    send_byte(8'h77);
    chk("pre_flush_t2h_level", t2h_level, 1);
    pulsebreak(3, a);
    chk("pre_flush_cmd_ack", a, 1);
    flush = 1;
    @(negedge clk) flush = 0;
    chk("flush_t2h_level", t2h_level, 0);
    chk("flush_h2t_level", h2t_level, 0);
    chk("flush_t2h_valid", t2h_valid, 0);
    chk("flush_noe", noe, 1);
    chk("flush_abort", abort_count, 2);
    sb_t2h.delete();
    q_h2t.delete();

    pulsebreak(3, a);
    chk("rst_seq_cmd_ack", a, 1);
    pulsebreak(1, a);
    pulsebreak(1, a);
    host_push(8'h99);
    pulse(a);
    pulse(a);
    @(negedge clk) req = 1;
    repeat (4) @(negedge clk);
    chk("rst_seq_p3_ack", !noe, 1);
    chk("rst_seq_abort_pre", abort_count, 3);
    #2 rst = 1;
    #1;
    chk("async_rst_noe", noe, 1);
    chk("async_rst_t2h_level", t2h_level, 0);
    chk("async_rst_h2t_level", h2t_level, 0);
    chk("async_rst_abort", abort_count, 0);
    chk("async_rst_h2t_ready", h2t_ready, 1);
    req = 0;
    q_h2t.delete();
    @(negedge clk) rst = 0;
    brk();
    pulsebreak(3, a);
    chk("post_rst_cmd_ack", a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
